uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter peripheral: a bus responder on the CPU's peripheral data bus (rd/wr/addr/wdata/rdata), selected when the CPU addresses the peripheral window. Software writes bytes to a data register. They are queued in a small FIFO and shifted out on `uart_tx` as 8N1 frames. A completion flag raises `irqout` when enabled. Single clock domain (the 25 MHz CPU clock); the baud rate comes from an internal divider.

## Interface
Parameters:
- `CLKS_PER_BIT`, 2604: clock cycles per UART bit (25 MHz / 9600). Minimum 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Power of two, minimum 2.
- `ADDR_TXD`, 32'h40000018: data register address.
- `ADDR_CON`, 32'h40000020: control/status register address.

Ports:
- `clk`  in  1: CPU clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rd`  in  1: bus read strobe, already qualified by the peripheral window.
- `wr`  in  1: bus write strobe, already qualified by the peripheral window.
- `addr`  in  32: byte address; full 32-bit compare.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data. Combinational, valid in the same cycle as `rd`.
- `uart_tx`  out  1: serial line, idle high.
- `irqout`  out  1: interrupt request, level.

## Operation
- Write to TXD: pushes `wdata[7:0]`; upper bits ignored.
  - Accepted if the FIFO count is below `FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and `overflow` is set.
- Write to CON: `wdata[0]` is latched into `irq_en`; all other bits are ignored.
- Read of TXD: returns 0.
- Read of CON returns {26'b0, overflow[5], busy[4], full[3], tx_done[2], 1'b0, irq_en[0]}.
  - `busy`: FSM is not IDLE.
  - `full`: count equals `FIFO_DEPTH`.
  - `tx_done` and `overflow` are sticky and clear on the edge ending a cycle with `rd` on CON.
  - If a set and a clear coincide, set wins.
- `rdata` is 0 when `rd` is low or the address is unmapped. Writes to unmapped addresses are ignored.
- `irqout` = `irq_en & tx_done`, registered-flag driven with no extra delay.
- FSM states:
  - IDLE: `uart_tx`=1. If the FIFO is non-empty: pop, load the shifter, go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. The bit counter runs 0..7, then go to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the end, set `tx_done`, then:
    - FIFO non-empty: pop and go to START directly (no idle gap).
    - Otherwise: go to IDLE.
- Baud counter: runs 0..`CLKS_PER_BIT`-1 and resets on every state or bit change. Width is clog2(`CLKS_PER_BIT`). FIFO pointers are clog2(`FIFO_DEPTH`) bits and wrap; the count is one bit wider.

## Timing
- Reset values:
  - `uart_tx`=1, `irqout`=0.
  - FSM IDLE, FIFO empty, `irq_en`=`tx_done`=`overflow`=0.
  - `rdata` is combinational (0 with no `rd`).
- Latency:
  - TXD write sampled at edge E1.
  - Pop and START entry at E2; `uart_tx` falls right after E2.
  - Frame length is exactly 10×`CLKS_PER_BIT` cycles.
  - `tx_done` and `irqout` rise on the edge that ends STOP.
- Reset mid-frame: `uart_tx` returns high immediately (asynchronously). The frame is aborted, the FIFO flushed and all flags cleared.

## Structure
- Package `uart_pkg`, shared with the receive side:
  - Register address constants.
  - CON bit index constants.
  - FSM state enum (IDLE, START, DATA, STOP).
- Sub-module `tx_fifo`: synchronous FIFO, parameterised width 8 and depth `FIFO_DEPTH`, with push/pop/full/empty/count. Simultaneous push and pop is legal when full.
- Top level holds the address decode, CON register, baud counter, shifter and FSM.

## Test plan
Run with `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Reset, then read CON → `rdata`=0, `uart_tx`=1, `irqout`=0. Read unmapped 0x40000010 → 0.
- Write 0x55 to TXD → `uart_tx` shows 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles, starting the cycle after E2. Then:
  - First CON read → bit2=1; second read → bit2=0.
- Write CON=1, then TXD=0xA3 → `irqout` rises exactly 40 cycles after E2 and falls on the edge after a CON read.
- Write 0x11 and 0x22 on consecutive edges → 80 contiguous frame cycles with no idle gap between the stop bit and the second start bit.
- Six TXD writes on edges E1..E6 → sixth dropped, CON bit5=1 and bit3=1 after E6; only bytes 1–5 appear on the line.
- Assert reset 10 cycles into a frame with 2 bytes queued → `uart_tx`=1 immediately. After release: no further frames, and CON reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, CON bit positions, transmitter FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;

    // Default register addresses in the peripheral window
    localparam logic [31:0] UART_ADDR_TXD = 32'h40000018;
    localparam logic [31:0] UART_ADDR_CON = 32'h40000020;

    // CON register bit positions
    localparam int CON_IRQ_EN   = 0;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_FULL     = 3;
    localparam int CON_BUSY     = 4;
    localparam int CON_OVERFLOW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
//
// Ports: clk/reset (async active-low), push/push_dat, pop/pop_dat,
//        full, empty, count (occupancy, one bit wider than the pointers).
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // pointers wrap naturally (power-of-two depth)
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observable when cnt_q says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXD write queues a byte, CON holds irq enable and status.
// Latency: byte written at edge E1 is popped at E2; line falls right after E2; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus; a TXD write to a full FIFO (no same-edge pop) is dropped and flags overflow.
//
// Ports: clk, reset (async active-low), rd/wr/addr/wdata/rdata (combinational rdata),
//        uart_tx (serial line, idle high), irqout (level, irq_en & tx_done).
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 2604,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ADDR_TXD     = UART_ADDR_TXD,
    parameter logic [31:0] ADDR_CON     = UART_ADDR_CON
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irqout
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          irq_en_q, irq_en_d;
    logic          tx_done_q, tx_done_d;
    logic          overflow_q, overflow_d;

    logic          wr_txd, wr_con, rd_con;
    logic          baud_end, tx_set;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dat;
    logic [FW:0]   fifo_count;
    logic          unused_bits;

    assign wr_txd   = wr && (addr == ADDR_TXD);
    assign wr_con   = wr && (addr == ADDR_CON);
    assign rd_con   = rd && (addr == ADDR_CON);
    assign baud_end = (baud_q == BAUD_LAST);

    assign unused_bits = ^{wdata[31:8], fifo_count};

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_txd),
        .push_dat (wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Transmit FSM: next state, baud/bit counters, shifter and FIFO pop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_set   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;  // next data bit moves to shift_q[0]
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    tx_set = 1'b1;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line is decoded from state so an async reset returns it high immediately.
    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_q[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // Sticky flags: a set on the same edge as a CON read wins over the clear.
    always_comb begin
        irq_en_d   = wr_con ? wdata[0] : irq_en_q;
        tx_done_d  = tx_set | (tx_done_q & ~rd_con);
        overflow_d = (wr_txd & fifo_full & ~fifo_pop) | (overflow_q & ~rd_con);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            irq_en_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            irq_en_q   <= irq_en_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_con) begin
            rdata[CON_IRQ_EN]   = irq_en_q;
            rdata[CON_TX_DONE]  = tx_done_q;
            rdata[CON_FULL]     = fifo_full;
            rdata[CON_BUSY]     = (state_q != IDLE);
            rdata[CON_OVERFLOW] = overflow_q;
        end
    end

    assign irqout = irq_en_q & tx_done_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] A_TXD = 32'h40000018;
    localparam logic [31:0] A_CON = 32'h40000020;
    localparam logic [31:0] A_BAD = 32'h40000010;

    typedef logic [7:0] byte_list_t[$];
    typedef logic       bit_list_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        uart_tx, irqout;

    int errors = 0;
    int checks = 0;
    bit_list_t line_q;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_TXD     (A_TXD),
        .ADDR_CON     (A_CON)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .irqout  (irqout)
    );

    // ---------------- reference model ----------------
    // Expected line: one idle sample (the cycle of the first write), then one
    // 8N1 frame per accepted byte back to back, then `tail` idle samples.
    function automatic bit_list_t model_line(input byte_list_t b, input int tail);
        bit_list_t q;
        q.push_back(1'b1);
        foreach (b[i]) begin
            logic [7:0] v;
            v = b[i];
            for (int c = 0; c < CPB; c++) q.push_back(1'b0);
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < CPB; c++) q.push_back(v[k]);
            for (int c = 0; c < CPB; c++) q.push_back(1'b1);
        end
        for (int c = 0; c < tail; c++) q.push_back(1'b1);
        return q;
    endfunction

    // Burst of K writes on consecutive edges into an idle transmitter: the first
    // byte leaves the FIFO on the next edge, so DEPTH more fit behind it.
    function automatic int accepted_count(input int k);
        return (k < DEPTH + 1) ? k : DEPTH + 1;
    endfunction

    function automatic int first_diff(input bit_list_t a, input bit_list_t e);
        int n;
        n = (a.size() < e.size()) ? a.size() : e.size();
        for (int i = 0; i < n; i++)
            if (a[i] !== e[i]) return i;
        if (a.size() != e.size()) return n;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        line_q.push_back(uart_tx);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step();
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1;
        d = rdata;
        step();
        rd = 1'b0; addr = '0;
    endtask

    task automatic push_burst(input byte_list_t b);
        wr = 1'b1; addr = A_TXD;
        foreach (b[i]) begin
            wdata = $urandom();
            wdata[7:0] = b[i];
            step();
        end
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic wait_line(input int n);
        while (line_q.size() < n) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1 || irqout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: uart_tx=%b irqout=%b, required 1/0", uart_tx, irqout);
        end
        reset = 1'b1;
        step();
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_con: got %h, required 0", d); end
        bus_read(A_BAD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", d); end
        bus_read(A_TXD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txd_read: got %h, required 0", d); end
        bus_write(A_BAD, 32'hFFFF_FFFF);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_write: CON=%h, required 0", d); end
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL idle_line: uart_tx=%b, required 1", uart_tx); end
    endtask

    task automatic test_single_frame();
        byte_list_t b;
        bit_list_t  e;
        logic [31:0] d;
        int idx;
        b.push_back(8'h55);
        e = model_line(b, 3);
        line_q.delete();
        push_burst(b);
        wait_line(e.size());
        idx = first_diff(line_q, e);
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL single_frame_line: first difference at sample %0d (got %0d samples, required %0d)",
                     idx, line_q.size(), e.size());
        end
        rd = 1'b0; addr = A_CON;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_rd: got %h, required 0", rdata); end
        addr = '0;
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL tx_done_first_read: got %h, required 4", d); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL tx_done_second_read: got %h, required 0", d); end
    endtask

    task automatic test_irq();
        byte_list_t b;
        bit_list_t  e;
        logic [31:0] d;
        int n;
        int idx;
        bus_write(A_CON, 32'hFFFF_FFF1);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL irq_en_set: CON=%h, required 1", d); end
        b.push_back(8'hA3);
        line_q.delete();
        push_burst(b);
        n = 0;
        while (irqout !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        // n counts samples after E1; sample n sits just after edge E(n+1).
        checks++;
        if (n - 1 != 10 * CPB) begin
            errors++;
            $display("FAIL irq_latency: irqout rose %0d cycles after E2, required %0d", n - 1, 10 * CPB);
        end
        e = model_line(b, 1);
        idx = first_diff(line_q, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL irq_frame_line: first difference at sample %0d", idx); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL irq_con: got %h, required 5", d); end
        checks++;
        if (irqout !== 1'b0) begin errors++; $display("FAIL irq_clear: irqout=%b, required 0", irqout); end
        bus_write(A_CON, 32'h0);
    endtask

    task automatic test_back_to_back();
        byte_list_t b;
        bit_list_t  e;
        logic [31:0] d;
        int idx;
        b.push_back(8'h11);
        b.push_back(8'h22);
        e = model_line(b, 3);
        line_q.delete();
        push_burst(b);
        wait_line(e.size());
        idx = first_diff(line_q, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL back_to_back_line: first difference at sample %0d", idx); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL back_to_back_con: got %h, required 4", d); end
    endtask

    task automatic test_overflow();
        byte_list_t b, acc;
        bit_list_t  e;
        logic [31:0] d;
        int idx;
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom()));
        for (int i = 0; i < accepted_count(6); i++) acc.push_back(b[i]);
        e = model_line(acc, 3);
        line_q.delete();
        push_burst(b);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h38) begin errors++; $display("FAIL overflow_con: got %h, required 38", d); end
        wait_line(e.size());
        idx = first_diff(line_q, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL overflow_line: first difference at sample %0d", idx); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL overflow_cleared: got %h, required 4", d); end
    endtask

    task automatic test_random_bursts();
        for (int it = 0; it < 4; it++) begin
            byte_list_t b, acc;
            bit_list_t  e;
            logic [31:0] d, exp_con;
            int k, idx;
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) b.push_back(8'($urandom()));
            for (int i = 0; i < accepted_count(k); i++) acc.push_back(b[i]);
            e = model_line(acc, 2);
            exp_con = (k > DEPTH + 1) ? 32'h24 : 32'h4;
            line_q.delete();
            push_burst(b);
            wait_line(e.size());
            idx = first_diff(line_q, e);
            checks++;
            if (idx != -1) begin
                errors++;
                $display("FAIL random_line[%0d]: k=%0d first difference at sample %0d", it, k, idx);
            end
            bus_read(A_CON, d);
            checks++;
            if (d !== exp_con) begin
                errors++;
                $display("FAIL random_con[%0d]: got %h, required %h", it, d, exp_con);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_list_t b;
        bit_list_t  e;
        logic [31:0] d;
        int idx;
        bus_write(A_CON, 32'h1);
        b.push_back(8'h00);
        b.push_back(8'($urandom()));
        b.push_back(8'($urandom()));
        line_q.delete();
        push_burst(b);
        // Now 2 cycles into the frame; advance to 10 (bit 1 of 0x00 -> line low).
        repeat (8) step();
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_frame_line: uart_tx=%b, required 0", uart_tx); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || irqout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: uart_tx=%b irqout=%b, required 1/0", uart_tx, irqout);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        line_q.delete();
        repeat (60) step();
        for (int i = 0; i < 60; i++) e.push_back(1'b1);
        idx = first_diff(line_q, e);
        checks++;
        if (idx != -1) begin errors++; $display("FAIL post_reset_idle: line low at sample %0d", idx); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_con: got %h, required 0", d); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_irq();
        test_back_to_back();
        test_overflow();
        test_random_bursts();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
